tmr_cnt_gen: RTL
================

# tmr_cnt_gen

Parametrised, single-clock timer counter core for the 8-bit timer family and its wider derivatives. It counts qualified `cnt_tick` pulses in free-run up, down or up/down (centre-aligned) mode, optionally one-shot, against a programmable period (`reload_value`). It generates overflow, underflow and compare-match pulses. It sits between the clock-select/prescaler logic, which produces `cnt_tick`, and the register/interrupt block, which consumes `TCNT` and the pulses.

## Interface
- `CNT_WIDTH`, default `` `DATA_WIDTH `` (8): counter and value width.
- `TCNT_RST`, default 0: reset value of `TCNT`.

- `pclk`  in  1  system clock; all logic is on the rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `cnt_tick`  in  1  single-`pclk` pulse qualifying one count step.
- `cnt_start`  in  1  pulse; enters RUN.
- `cnt_stop`  in  1  pulse; enters IDLE, and `TCNT` holds.
- `cnt_load`  in  1  pulse; `TCNT <= load_value`.
- `load_value`  in  CNT_WIDTH  value loaded by `cnt_load`.
- `reload_value`  in  CNT_WIDTH  period: top in up and up/down modes, restart value in down mode.
- `cmp_value`  in  CNT_WIDTH  compare value.
- `cnt_mode`  in  2  00 = up, 01 = down, 10 = up/down, 11 = reserved (behaves as up).
- `one_shot`  in  1  1 = return to IDLE after the first overflow or underflow.
- `TCNT`  out  CNT_WIDTH  current count.
- `cnt_running`  out  1  1 in RUN.
- `cnt_dir`  out  1  current direction; 0 = up, 1 = down.
- `ovf_pulse`  out  1  one-cycle overflow or top-turn pulse.
- `udf_pulse`  out  1  one-cycle underflow or bottom-turn pulse.
- `cmp_pulse`  out  1  one-cycle compare-match pulse.

## Operation
**States.** Two states: IDLE and RUN.
- IDLE → RUN on `cnt_start`.
- RUN → IDLE on `cnt_stop`.
- RUN → IDLE when `one_shot` = 1 and a step produces `ovf_pulse` or `udf_pulse`.
- `cnt_start` while already in RUN has no effect.

**Priority per cycle**, highest first: `preset`, `cnt_load`, `cnt_stop`, `cnt_start`, `cnt_tick`. A lower-priority item in the same cycle is ignored, with two exceptions:
- `cnt_load` does not change state, so `cnt_stop` and `cnt_start` still act alongside it. Only `cnt_tick` is suppressed.
- `cnt_load` also forces `cnt_dir` to 0.

**Step rules.** A step happens only on `cnt_tick` while in RUN.
- Up mode: if `TCNT >= reload_value` → `TCNT <= 0` and `ovf_pulse`; else `TCNT + 1`.
- Down mode: if `TCNT == 0` → `TCNT <= reload_value` and `udf_pulse`; else `TCNT - 1`.
- Up/down mode, direction up: if `TCNT >= reload_value` → `TCNT - 1`, `cnt_dir <= 1`, `ovf_pulse`; else `TCNT + 1`.
- Up/down mode, direction down: if `TCNT == 0` → `TCNT <= 1`, `cnt_dir <= 0`, `udf_pulse`; else `TCNT - 1`.
- Up/down period is 2 × `reload_value` ticks.
- Up/down with `reload_value == 0`: `TCNT` stays 0, `cnt_dir` stays 0, and `ovf_pulse` fires on every step.

**Compare.** `cmp_pulse` fires when a step's new `TCNT == cmp_value`. Loads and reset never raise it.

**Arithmetic.** Modulo 2^CNT_WIDTH; no other wrap exists. The `>=` test guarantees recovery when `reload_value` is reprogrammed below `TCNT`.

**Mode changes.** A change of `cnt_mode` takes effect on the next step. `cnt_dir` is forced to 0 whenever `cnt_mode` ≠ 10.

**Reset.** Reset values: `TCNT = TCNT_RST`, state IDLE, `cnt_running = 0`, `cnt_dir = 0`, and all pulses 0. Asserting reset mid-count aborts the count with no pulse.

## Timing
- All outputs are registered.
- `TCNT`, `cnt_dir` and the pulses update on the edge that samples `cnt_tick`, so they are visible one cycle after the tick cycle.
- Each pulse is high for exactly one `pclk`.
- `cnt_running` rises on the edge that samples `cnt_start`. A tick in the start cycle is ignored; counting begins with the next tick.
- In one-shot mode, `cnt_running` falls on the same edge that raises the terminating pulse.
- `cnt_load` result is visible one cycle later.
- Back-to-back ticks on every cycle are supported, giving full-rate counting.

## Test plan
1. **Reset mid-count.** Running at `TCNT` = 0x37; assert `preset` for 1 cycle → next edge: `TCNT` = 0x00, `cnt_running` = 0, all pulses 0. Further ticks leave `TCNT` unchanged.
2. **Up wrap.** Mode 00, `reload_value` = 0xFF; load 0xFE, start, 3 ticks → `TCNT` = 0xFF, then 0x00 with `ovf_pulse`, then 0x01.
3. **Down one-shot.** Mode 01, `one_shot` = 1, `reload_value` = 0x05; load 0x02, start, ticks → 0x01, 0x00, then 0x05 with `udf_pulse` and `cnt_running` = 0 on that edge. Further ticks hold 0x05.
4. **Up/down.** Mode 10, `reload_value` = 0x03, from 0 → 1, 2, 3, 2 (`ovf_pulse`, `cnt_dir` = 1), 1, 0, 1 (`udf_pulse`, `cnt_dir` = 0).
5. **Compare.** Mode 00, `cmp_value` = 0x10; run from 0x0E → 0x0F, 0x10 with `cmp_pulse`, 0x11 with no pulse. Loading 0x10 produces no `cmp_pulse`.
6. **Simultaneous events.**
   - `cnt_load` (0x80) with `cnt_tick` in the same cycle → `TCNT` = 0x80, no step, no pulse.
   - `cnt_stop` with `cnt_start` in the same cycle from IDLE → stays IDLE.
   - `reload_value` reprogrammed to 0x04 while `TCNT` = 0x09 in up mode → next tick gives 0x00 with `ovf_pulse`.

Source files
------------

// File: rtl/tmr_cnt_gen_if.sv
// Timer counter bus: control pulses and programming values in,
// count value, run status and event pulses out.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface tmr_cnt_gen_if #(
    parameter int unsigned CNT_WIDTH = `DATA_WIDTH
);
    logic                 cnt_tick;
    logic                 cnt_start;
    logic                 cnt_stop;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] load_value;
    logic [CNT_WIDTH-1:0] reload_value;
    logic [CNT_WIDTH-1:0] cmp_value;
    logic [1:0]           cnt_mode;
    logic                 one_shot;
    logic [CNT_WIDTH-1:0] TCNT;
    logic                 cnt_running;
    logic                 cnt_dir;
    logic                 ovf_pulse;
    logic                 udf_pulse;
    logic                 cmp_pulse;

    modport master (
        output cnt_tick, cnt_start, cnt_stop, cnt_load,
        output load_value, reload_value, cmp_value,
        output cnt_mode, one_shot,
        input  TCNT, cnt_running, cnt_dir,
        input  ovf_pulse, udf_pulse, cmp_pulse
    );

    modport slave (
        input  cnt_tick, cnt_start, cnt_stop, cnt_load,
        input  load_value, reload_value, cmp_value,
        input  cnt_mode, one_shot,
        output TCNT, cnt_running, cnt_dir,
        output ovf_pulse, udf_pulse, cmp_pulse
    );
endinterface

// File: rtl/tmr_cnt_gen.sv
// Timer counter core: up, down and centre-aligned counting of
// qualified ticks with overflow, underflow and compare pulses.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tmr_cnt_gen #(
    parameter int unsigned          CNT_WIDTH = `DATA_WIDTH,
    parameter logic [CNT_WIDTH-1:0] TCNT_RST  = '0
) (
    input logic          pclk,
    input logic          preset,
    tmr_cnt_gen_if.slave bus
);
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                 dir_q, dir_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 cmp_q, cmp_d;
    logic                 step;

    // Next state: load > stop > start > tick; one step per tick.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        dir_d   = dir_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        cmp_d   = 1'b0;
        step    = 1'b0;

        if (bus.cnt_load) begin
            tcnt_d = bus.load_value;
            dir_d  = 1'b0;
            if (bus.cnt_stop) begin
                state_d = ST_IDLE;
            end else if (bus.cnt_start) begin
                state_d = ST_RUN;
            end
        end else if (bus.cnt_stop) begin
            state_d = ST_IDLE;
        end else if (bus.cnt_start) begin
            state_d = ST_RUN;
        end else begin
            step = bus.cnt_tick && (state_q == ST_RUN);
        end

        if (step) begin
            case (bus.cnt_mode)
                2'b01: begin
                    if (tcnt_q == '0) begin
                        tcnt_d = bus.reload_value;
                        udf_d  = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q - ONE;
                    end
                end
                2'b10: begin
                    if (!dir_q) begin
                        if (tcnt_q >= bus.reload_value) begin
                            ovf_d = 1'b1;
                            // A zero period pins the count at the bottom.
                            if (bus.reload_value == '0) begin
                                tcnt_d = '0;
                                dir_d  = 1'b0;
                            end else begin
                                tcnt_d = tcnt_q - ONE;
                                dir_d  = 1'b1;
                            end
                        end else begin
                            tcnt_d = tcnt_q + ONE;
                        end
                    end else if (tcnt_q == '0) begin
                        tcnt_d = ONE;
                        dir_d  = 1'b0;
                        udf_d  = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q - ONE;
                    end
                end
                default: begin
                    if (tcnt_q >= bus.reload_value) begin
                        tcnt_d = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + ONE;
                    end
                end
            endcase
            cmp_d = (tcnt_d == bus.cmp_value);
            if (bus.one_shot && (ovf_d || udf_d)) begin
                state_d = ST_IDLE;
            end
        end

        if (bus.cnt_mode != 2'b10) begin
            dir_d = 1'b0;
        end
    end

    // Registered state and outputs with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= TCNT_RST;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            cmp_q   <= cmp_d;
        end
    end

    assign bus.TCNT        = tcnt_q;
    assign bus.cnt_running = (state_q == ST_RUN);
    assign bus.cnt_dir     = dir_q;
    assign bus.ovf_pulse   = ovf_q;
    assign bus.udf_pulse   = udf_q;
    assign bus.cmp_pulse   = cmp_q;
endmodule
